// File: rtl/n64_pkg.sv
// n64_pkg: shared state encoding, command codes and response helpers for the N64 device model
`timescale 1ns/1ps
package n64_pkg;
  typedef enum logic [2:0] {IDLE, RX, TURN, TX, STOP} state_t;
  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_POLL   = 8'h01;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  function automatic logic is_status(input logic [7:0] c);
    return c == CMD_STATUS || c == CMD_RESET;
  endfunction
endpackage

// File: rtl/n64_line_sync.sv
// n64_line_sync: two-flop synchroniser for the single-wire bus with falling/rising edge detect
`timescale 1ns/1ps
module n64_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  output logic sync,
  output logic fall,
  output logic rise
);
  logic s1, s2, s3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= data_in;
      s2 <= s1;
      s3 <= s2;
    end
  end
  assign sync = s2;
  assign fall = s3 & ~s2;
  assign rise = ~s3 & s2;
endmodule

// File: rtl/n64_device_model.sv
// n64_device_model: single-wire N64 controller device; receives a command byte and answers
// with the status word or the button word, both sent MSB first.
`timescale 1ns/1ps
module n64_device_model import n64_pkg::*; #(
  parameter int BIT_TICKS     = 40,
  parameter int SHORT_TICKS   = 10,
  parameter int LONG_TICKS    = 30,
  parameter int TURN_TICKS    = 80,
  parameter int TIMEOUT_TICKS = 200,
  parameter int OPEN_DRAIN    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  inout  wire         data,
  input  logic [23:0] status_word,
  input  logic [31:0] buttons,
  output logic        busy,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        rx_error
);
  logic din, fall, rise, drive_low, tx_phase;
  state_t state;
  logic [15:0] cnt, hcnt;
  logic [3:0] nbits;
  logic [7:0] shreg;
  logic [31:0] resp;
  logic [5:0] left;
  n64_line_sync u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data),
    .sync(din),
    .fall(fall),
    .rise(rise)
  );
  assign tx_phase  = state == TX || state == STOP;
  assign drive_low = (state == TX && cnt < (resp[31] ? 16'(SHORT_TICKS) : 16'(LONG_TICKS))) ||
                     (state == STOP && cnt < 16'(SHORT_TICKS));
  assign data = drive_low ? 1'b0 : (OPEN_DRAIN == 0 && tx_phase) ? 1'b1 : 1'bz;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      nbits     <= '0;
      shreg     <= '0;
      resp      <= '0;
      left      <= '0;
      cmd_valid <= 1'b0;
      cmd_byte  <= '0;
      rx_error  <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      rx_error  <= 1'b0;
      case (state)
        IDLE: if (fall && en) begin
          state <= RX;
          cnt   <= 16'd1;
          hcnt  <= '0;
          nbits <= '0;
          shreg <= '0;
        end
        RX: begin
          // cnt tracks low time of the current pulse, hcnt the high gap since the last rise
          if (fall) cnt <= 16'd1;
          else if (!din && cnt < 16'(BIT_TICKS)) cnt <= cnt + 16'd1;
          if (rise) hcnt <= 16'd1;
          else if (din) hcnt <= hcnt + 16'd1;
          if (din && !rise && hcnt >= 16'(TIMEOUT_TICKS - 1)) begin
            rx_error <= 1'b1;
            state    <= IDLE;
          end else if (rise && nbits == 4'd8) begin
            cmd_valid <= 1'b1;
            cmd_byte  <= shreg;
            cnt       <= '0;
            if (is_status(shreg)) begin
              resp  <= {status_word, 8'h00};
              left  <= 6'd24;
              state <= TURN;
            end else if (shreg == CMD_POLL) begin
              resp  <= buttons;
              left  <= 6'd32;
              state <= TURN;
            end else begin
              rx_error <= 1'b1;
              state    <= IDLE;
            end
          end else if (rise) begin
            shreg <= {shreg[6:0], cnt < 16'(BIT_TICKS / 2)};
            nbits <= nbits + 4'd1;
          end
        end
        TURN: begin
          cnt   <= cnt == 16'(TURN_TICKS - 1) ? '0 : cnt + 16'd1;
          state <= cnt == 16'(TURN_TICKS - 1) ? TX : TURN;
        end
        TX: if (cnt == 16'(BIT_TICKS - 1)) begin
          cnt   <= '0;
          resp  <= {resp[30:0], 1'b0};
          left  <= left - 6'd1;
          state <= left == 6'd1 ? STOP : TX;
        end else cnt <= cnt + 16'd1;
        STOP: begin
          cnt   <= cnt == 16'(BIT_TICKS - 1) ? '0 : cnt + 16'd1;
          state <= cnt == 16'(BIT_TICKS - 1) ? IDLE : STOP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_n64_device_model.sv
// tb_n64_device_model: host-side bench; drives commands on the wire and decodes the device reply
`timescale 1ns/1ps
module tb_n64_device_model;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic host_low = 1'b0;
  logic [23:0] status_word = 24'h050002;
  logic [31:0] buttons = 32'hA5A5_0F0F;
  logic busy, cmd_valid, rx_error;
  logic [7:0] cmd_byte;
  wire data;
  pullup (data);
  assign data = host_low ? 1'b0 : 1'bz;
  n64_device_model dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .data(data),
    .status_word(status_word),
    .buttons(buttons),
    .busy(busy),
    .cmd_valid(cmd_valid),
    .cmd_byte(cmd_byte),
    .rx_error(rx_error)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int cv_cnt = 0, cv_cyc = 0, err_cnt = 0, err_cyc = 0, lowrun = 0, last_rel = 0;
  logic [7:0] cv_byte = '0;
  bit bits_q[$];
  int fall_q[$];
  always @(posedge clk) cyc <= cyc + 1;
  // event recorder: pulses and every low run the device puts on the wire
  always @(negedge clk) begin
    if (cmd_valid) begin cv_cnt++; cv_cyc = cyc; cv_byte = cmd_byte; end
    if (rx_error) begin err_cnt++; err_cyc = cyc; end
    if (!host_low && data === 1'b0) begin
      if (lowrun == 0) fall_q.push_back(cyc);
      lowrun++;
    end else if (lowrun > 0) begin
      bits_q.push_back(lowrun < 20);
      lowrun = 0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic int ref_len(input logic [7:0] c);
    return (c == 8'h00 || c == 8'hFF) ? 24 : (c == 8'h01) ? 32 : 0;
  endfunction
  function automatic logic [31:0] ref_word(input logic [7:0] c);
    return c == 8'h01 ? buttons : {8'h00, status_word};
  endfunction
  task automatic host_pulse(input int low, input int total);
    @(posedge clk); #1 host_low = 1'b1;
    repeat (low) @(posedge clk);
    #1 host_low = 1'b0;
    last_rel = cyc;
    repeat (total - low - 1) @(posedge clk);
  endtask
  task automatic send_bits(input logic [7:0] c, input int n);
    for (int i = 7; i > 7 - n; i--) host_pulse(c[i] ? 10 : 30, 40);
  endtask
  task automatic send_cmd(input logic [7:0] c);
    send_bits(c, 8);
    host_pulse(10, 11);
  endtask
  task automatic run_txn(input logic [7:0] c, input bit mid);
    int q0, f0, c0, e0, len, n;
    logic [31:0] w, expw;
    len = ref_len(c);
    expw = ref_word(c);
    q0 = bits_q.size(); f0 = fall_q.size(); c0 = cv_cnt; e0 = err_cnt;
    send_cmd(c);
    n = 0;
    while (cv_cnt == c0 && n < 20) begin @(negedge clk); n++; end
    chk("cmd_valid_count", cv_cnt - c0, 1);
    chk("cmd_byte", {24'h0, cv_byte}, {24'h0, c});
    if (len == 0) begin
      repeat (100) @(negedge clk);
      chk("unknown_rx_error", err_cnt - e0, 1);
      chk("unknown_busy", {31'h0, busy}, 0);
      chk("unknown_no_drive", bits_q.size() - q0, 0);
    end else begin
      n = 0;
      while (busy && n < 3000) begin
        @(negedge clk); n++;
        if (mid && n == 400) buttons = ~buttons ^ $urandom;
      end
      chk("txn_done", {31'h0, n < 3000}, 1);
      chk("bit_count", bits_q.size() - q0, len + 1);
      w = '0;
      for (int i = 0; i < len && q0 + i < bits_q.size(); i++) w = {w[30:0], bits_q[q0 + i]};
      chk("reply_word", w, expw);
      chk("stop_bit", {31'h0, q0 + len < bits_q.size() ? bits_q[q0 + len] : 1'b0}, 1);
      chk("turnaround", f0 < fall_q.size() ? fall_q[f0] - cv_cyc : -1, 80);
      chk("no_error", err_cnt - e0, 0);
    end
    repeat (20) @(negedge clk);
  endtask
  initial begin
    int n, e0, c0, q0;
    logic [7:0] rc;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_cmd_valid", {31'h0, cmd_valid}, 0);
    chk("rst_rx_error", {31'h0, rx_error}, 0);
    chk("rst_cmd_byte", {24'h0, cmd_byte}, 0);
    chk("rst_line_released", {31'h0, data}, 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    run_txn(8'h01, 1'b0);
    run_txn(8'hFF, 1'b0);
    run_txn(8'h3C, 1'b0);
    e0 = err_cnt;
    send_bits(8'hA0, 4);
    n = 0;
    while (err_cnt == e0 && n < 300) begin @(negedge clk); n++; end
    chk("timeout_error", err_cnt - e0, 1);
    chk("timeout_delay_ok", {31'h0, err_cyc - last_rel >= 196 && err_cyc - last_rel <= 206}, 1);
    chk("timeout_idle", {31'h0, busy}, 0);
    repeat (10) @(negedge clk);
    run_txn(8'h01, 1'b0);
    buttons = $urandom;
    run_txn(8'h01, 1'b1);
    for (int k = 0; k < 4; k++) begin
      status_word = 24'($urandom);
      buttons = $urandom;
      rc = k == 3 ? 8'($urandom_range(2, 254)) : (k == 0 ? 8'h00 : k == 1 ? 8'h01 : 8'hFF);
      run_txn(rc, 1'b0);
    end
    en = 1'b0;
    c0 = cv_cnt; q0 = bits_q.size();
    send_cmd(8'h01);
    repeat (200) @(negedge clk);
    chk("en_off_no_cmd", cv_cnt - c0, 0);
    chk("en_off_no_reply", bits_q.size() - q0, 0);
    chk("en_off_busy", {31'h0, busy}, 0);
    en = 1'b1;
    repeat (10) @(negedge clk);
    send_cmd(8'h01);
    n = 0;
    while (!(busy && data === 1'b0) && n < 400) begin @(negedge clk); n++; end
    chk("midtx_reached", {31'h0, n < 400}, 1);
    rst_n = 1'b0;
    #1;
    chk("midtx_rst_released", {31'h0, data}, 1);
    chk("midtx_rst_busy", {31'h0, busy}, 0);
    chk("midtx_rst_cmd_byte", {24'h0, cmd_byte}, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    run_txn(8'h00, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
